// File: rtl/mont_mul_iter.sv
// Radix-2 iterative Montgomery multiplier: out = a*b*2^-WIDTH mod m, one bit of a per clock.
// Optional operand checker under `define MONT_OPERAND_CHECK_EN (even m, a>=m or b>=m -> err).
module mont_mul_iter #(
    parameter int WIDTH = 255,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_reg, b_reg, m_reg;
    logic [WIDTH+1:0]   t;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH+1:0]   u1, u2;
    logic [WIDTH-1:0]   diff, res;
    logic               ge;

    // a_reg is shifted right each iteration so its LSB is always the current bit.
    always_comb begin
        u1   = t + (a_reg[0] ? {2'b00, b_reg} : '0);
        u2   = u1 + (u1[0] ? {2'b00, m_reg} : '0);
        ge   = (t >= {2'b00, m_reg});
        // t < 2m, so when t >= m the difference fits in WIDTH bits.
        diff = t[WIDTH-1:0] - m_reg;
        res  = ge ? diff : t[WIDTH-1:0];
    end

`ifdef MONT_OPERAND_CHECK_EN
    logic chk_fail, err_pend;
    // Evaluated on the first ITER cycle, while a_reg is still unshifted.
    assign chk_fail = (cnt == '0) &&
                      (~m_reg[0] || (a_reg >= m_reg) || (b_reg >= m_reg));
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = ITER;
            ITER: begin
`ifdef MONT_OPERAND_CHECK_EN
                if (chk_fail || cnt == LAST) state_nx = FINAL;
`else
                if (cnt == LAST) state_nx = FINAL;
`endif
            end
            FINAL: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            m_reg <= '0;
            t     <= '0;
            cnt   <= '0;
            out   <= '0;
            done  <= 1'b0;
`ifdef MONT_OPERAND_CHECK_EN
            err      <= 1'b0;
            err_pend <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        m_reg <= m;
                        t     <= '0;
                        cnt   <= '0;
`ifdef MONT_OPERAND_CHECK_EN
                        err_pend <= 1'b0;
`endif
                    end
                end
                ITER: begin
                    t     <= u2 >> 1;
                    a_reg <= a_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
`ifdef MONT_OPERAND_CHECK_EN
                    if (chk_fail) err_pend <= 1'b1;
`endif
                end
                FINAL: begin
                    done <= 1'b1;
`ifdef MONT_OPERAND_CHECK_EN
                    out <= err_pend ? '0 : res;
                    err <= err_pend;
`else
                    out <= res;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef MONT_OPERAND_CHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mont_mul_iter.sv
// Bench for mont_mul_iter: 8-bit instance for protocol/value tests, 255-bit instance for Curve25519.
module tb_mont_mul_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [7:0] a, b, m, out;
    logic       busy, done, err;

    logic         start_w;
    logic [254:0] a_w, b_w, m_w, out_w;
    logic         busy_w, done_w, err_w;

    mont_mul_iter #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m),
        .busy(busy), .done(done), .out(out), .err(err)
    );

    mont_mul_iter #(.WIDTH(255), .CNT_W(9)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .a(a_w), .b(b_w), .m(m_w),
        .busy(busy_w), .done(done_w), .out(out_w), .err(err_w)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] out;
        logic       err;
    } exp_t;

    exp_t         exp_q[$];
    logic [254:0] exp_w_q[$];

    // Reference: a*b*R^-1 mod m, with R^-1 = (1 + k*m) / (R mod m) for the k that divides exactly.
    function automatic logic [255:0] mont_ref(input logic [255:0] fa, input logic [255:0] fb,
                                              input logic [255:0] fm, input int w);
        logic [511:0] mm, r, rinv, num, prod, res;
        logic         found;
        mm    = {256'b0, fm};
        r     = (512'd1 << w) % mm;
        rinv  = '0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            num = 512'd1 + 512'(k) * mm;
            if (num % r == '0) begin
                rinv  = num / r;
                found = 1'b1;
            end
        end
        prod = ({256'b0, fa} * {256'b0, fb}) % mm;
        res  = (prod * rinv) % mm;
        return res[255:0];
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done out=%h err=%b", out, err);
            end else begin
                e = exp_q.pop_front();
                if (out !== e.out || err !== e.err) begin
                    miscompares++;
                    $display("FAIL result got out=%h err=%b expected out=%h err=%b",
                             out, err, e.out, e.err);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] im);
        exp_t         e;
        logic [255:0] r;
        r     = mont_ref({248'b0, ia}, {248'b0, ib}, {248'b0, im}, 8);
        e.err = 1'b0;
`ifdef MONT_OPERAND_CHECK_EN
        e.err = (im[0] == 1'b0) || (ia >= im) || (ib >= im);
`endif
        e.out = e.err ? 8'h00 : r[7:0];
        exp_q.push_back(e);
    endtask

    // Called at posedge+1 while idle; returns at accept edge +1.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] im,
                         input bit push);
        if (push) push_exp(ia, ib, im);
        start = 1'b1;
        a = ia; b = ib; m = im;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, input int limit);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < limit);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
        start_w = 1'b0; a_w = '0; b_w = '0; m_w = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors += 5;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        if (out !== 8'h00) begin miscompares++; $display("FAIL reset_out got %h want 00", out); end
        if (err !== 1'b0)  begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
        if (busy_w !== 1'b0 || out_w !== '0) begin
            miscompares++; $display("FAIL reset_wide busy=%b out=%h want 0", busy_w, out_w);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_start busy=%b want 0", busy); end
    endtask

    task automatic test_basic;
        int n;
        issue(8'h01, 8'h0F, 8'hF1, 1);
        wait_done(n, 20);
        vectors += 2;
        if (n != 9) begin miscompares++; $display("FAIL basic_latency got %0d want 9", n); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width got %b want 0", done); end
    endtask

    task automatic test_async_reset;
        int n;
        issue(8'h23, 8'h45, 8'hF1, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors += 4;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL arst_done got %b want 0", done); end
        if (out !== 8'h00) begin miscompares++; $display("FAIL arst_out got %h want 00", out); end
        if (err !== 1'b0)  begin miscompares++; $display("FAIL arst_err got %b want 0", err); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(8'h23, 8'h45, 8'hF1, 1);
        wait_done(n, 20);
        vectors++;
        if (n != 9) begin miscompares++; $display("FAIL arst_recover_latency got %0d want 9", n); end
    endtask

    task automatic test_values;
        int n;
        logic [7:0] mods[4];
        logic [7:0] mm, ra, rb;
        mods[0] = 8'hF1; mods[1] = 8'hC5; mods[2] = 8'hFB; mods[3] = 8'h83;
        issue(8'hF0, 8'hF0, 8'hF1, 1);
        wait_done(n, 20);
        vectors++;
        if (n != 9) begin miscompares++; $display("FAIL sq_latency got %0d want 9", n); end
        issue(8'h00, 8'h55, 8'hF1, 1);
        wait_done(n, 20);
        vectors++;
        if (n != 9) begin miscompares++; $display("FAIL zero_latency got %0d want 9", n); end
        for (int i = 0; i < 8; i++) begin
            mm = mods[i % 4];
            ra = 8'($urandom_range(0, int'(mm) - 1));
            rb = 8'($urandom_range(0, int'(mm) - 1));
            issue(ra, rb, mm, 1);
            wait_done(n, 20);
            vectors++;
            if (n != 9) begin miscompares++; $display("FAIL rand_latency got %0d want 9", n); end
        end
    endtask

    task automatic test_busy_ignore;
        int n, extra;
        issue(8'h11, 8'h22, 8'hF1, 1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; a = 8'h99; b = 8'h77; m = 8'hC5;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, 20);
        vectors++;
        if (n != 4) begin miscompares++; $display("FAIL ignore_latency got %0d want 4", n); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        vectors++;
        if (extra != 0) begin miscompares++; $display("FAIL ignore_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        int n;
        push_exp(8'h5A, 8'h3C, 8'hFB);
        start = 1'b1; a = 8'h5A; b = 8'h3C; m = 8'hFB;
        @(posedge clk); #1;
        a = 8'h21; b = 8'h42; m = 8'hC5;
        push_exp(8'h21, 8'h42, 8'hC5);
        wait_done(n, 20);
        vectors++;
        if (n != 9) begin miscompares++; $display("FAIL b2b_first_latency got %0d want 9", n); end
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept busy=%b want 1", busy); end
        wait_done(n, 20);
        vectors++;
        if (n + 1 != 10) begin miscompares++; $display("FAIL b2b_period got %0d want 10", n + 1); end
        @(posedge clk); #1;
    endtask

    task automatic test_err;
        int n;
`ifdef MONT_OPERAND_CHECK_EN
        issue(8'h01, 8'h01, 8'hF0, 1);
        wait_done(n, 20);
        vectors++;
        if (n != 2) begin miscompares++; $display("FAIL err_even_m_latency got %0d want 2", n); end
        issue(8'hF5, 8'h01, 8'hF1, 1);
        wait_done(n, 20);
        vectors++;
        if (n != 2) begin miscompares++; $display("FAIL err_a_ge_m_latency got %0d want 2", n); end
        issue(8'h37, 8'h9A, 8'hF1, 1);
        wait_done(n, 20);
        vectors++;
        if (n != 9) begin miscompares++; $display("FAIL err_valid_latency got %0d want 9", n); end
`else
        issue(8'h37, 8'h9A, 8'hF1, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            vectors++;
            if (err !== 1'b0) begin miscompares++; $display("FAIL err_tied got %b want 0", err); end
        end while (!done && n < 20);
        vectors++;
        if (n != 9) begin miscompares++; $display("FAIL err_off_latency got %0d want 9", n); end
`endif
    endtask

    task automatic test_wide;
        logic [254:0] p, va[3], vb[3], got, want;
        logic [255:0] r;
        int n;
        p = {255{1'b1}} - 255'd18;
        va[0] = 255'd1; vb[0] = 255'd19;
        va[1] = 255'd1; vb[1] = 255'd38;
        va[2] = p - 255'd1; vb[2] = p - 255'd1;
        for (int i = 0; i < 3; i++) begin
            r = mont_ref({1'b0, va[i]}, {1'b0, vb[i]}, {1'b0, p}, 255);
            exp_w_q.push_back(r[254:0]);
            start_w = 1'b1; a_w = va[i]; b_w = vb[i]; m_w = p;
            @(posedge clk); #1;
            start_w = 1'b0;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!done_w && n < 300);
            vectors += 3;
            if (n != 256) begin miscompares++; $display("FAIL wide_latency[%0d] got %0d want 256", i, n); end
            got  = out_w;
            want = exp_w_q.pop_front();
            if (got !== want) begin miscompares++; $display("FAIL wide_out[%0d] got %h want %h", i, got, want); end
            if (err_w !== 1'b0) begin miscompares++; $display("FAIL wide_err[%0d] got %b want 0", i, err_w); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_values();
        test_busy_ignore();
        test_back_to_back();
        test_err();
        test_wide();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL pending_results got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
